serial_byte_loader: RTL and testbench

SERIAL_BYTE_LOADER -- requirements
Module: serial_byte_loader

---
 rtl/serial_byte_loader.sv | 152 +++++++++++++++
 tb/tb_serial_byte_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_loader.sv
// serial_byte_loader
//    Assembles a byte from a strobed serial stream. The byte may be followed by
//    an optional even-parity bit. The assembled byte is held in an output register
//    that has a Valid/Ready handshake toward a downstream 8-bit register.
//
//    Parameters
//       MSB_FIRST  1: first received bit lands in Q[7]; 0: lands in Q[0]
//       PARITY_EN  1: a 9th even-parity bit follows every 8 data bits
//
//    Ports
//       CLK      clock, rising edge
//       Clrn     asynchronous active-low reset
//       Start    one-cycle frame-start strobe (also restarts a frame in flight)
//       BitEn    one-cycle bit strobe; SDI is sampled only with BitEn=1
//       SDI      serial data in
//       Ready    downstream accepts Q when Ready=1 and Valid=1
//       Q        assembled byte
//       Valid    Q holds a byte not yet taken by downstream
//       Busy     frame in progress
//       ParErr   parity result for the byte on Q (1 = error)
//       Overrun  one-cycle pulse when a completed byte is dropped
//
//    state | meaning
//    ------+-----------------------------------------------
//    IDLE  | waiting for Start; BitEn ignored
//    SHIFT | collecting the 8 data bits
//    PAR   | data complete, waiting for the parity bit

module serial_byte_loader #(
   parameter bit MSB_FIRST = 1'b1,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic       CLK,
   input  logic       Clrn,
   input  logic       Start,
   input  logic       BitEn,
   input  logic       SDI,
   input  logic       Ready,
   output logic [7:0] Q,
   output logic       Valid,
   output logic       Busy,
   output logic       ParErr,
   output logic       Overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] cnt;
   logic [7:0] sr;

   logic [7:0] sr_next;
   logic       done;
   logic [7:0] done_data;
   logic       done_perr;

   assign sr_next = MSB_FIRST ? {sr[6:0], SDI} : {SDI, sr[7:1]};

   // Completion happens on the edge that samples the last bit of the frame.
   // That is the 8th data bit without parity, or the parity bit with it.
   // A coincident Start wins and discards the frame.
   always_comb begin
      done      = 1'b0;
      done_data = sr_next;
      done_perr = 1'b0;
      if ((state == SHIFT) && BitEn && !Start && (cnt == 3'd7) && !PARITY_EN) begin
         done = 1'b1;
      end
      if ((state == PAR) && BitEn && !Start) begin
         done      = 1'b1;
         done_data = sr;
         done_perr = ^{sr, SDI};
      end
   end

   always_ff @(posedge CLK or negedge Clrn) begin
      if (!Clrn) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         sr      <= 8'h00;
         Q       <= 8'h00;
         Valid   <= 1'b0;
         Busy    <= 1'b0;
         ParErr  <= 1'b0;
         Overrun <= 1'b0;
      end else begin
         Overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (Start) begin
                  state <= SHIFT;
                  Busy  <= 1'b1;
                  cnt   <= 3'd0;
                  sr    <= 8'h00;
               end
            end
            SHIFT: begin
               if (Start) begin
                  cnt <= 3'd0;
                  sr  <= 8'h00;
               end else if (BitEn) begin
                  sr  <= sr_next;
                  // cnt wraps to 0 on the 8th bit, ready for the next frame
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     if (PARITY_EN) begin
                        state <= PAR;
                     end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                     end
                  end
               end
            end
            PAR: begin
               if (Start) begin
                  state <= SHIFT;
                  cnt   <= 3'd0;
                  sr    <= 8'h00;
               end else if (BitEn) begin
                  state <= IDLE;
                  Busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase

         // Output register: a completed byte replaces Q only when the slot is
         // free or is being taken this very cycle; otherwise it is dropped.
         if (done) begin
            if (!Valid || Ready) begin
               Q      <= done_data;
               ParErr <= done_perr;
               Valid  <= 1'b1;
            end else begin
               Overrun <= 1'b1;
            end
         end else if (Valid && Ready) begin
            Valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench for serial_byte_loader. Three instances share the serial stimulus:
//    msb : MSB_FIRST=1, PARITY_EN=0
//    lsb : MSB_FIRST=0, PARITY_EN=0
//    par : MSB_FIRST=1, PARITY_EN=1
// Each frame is driven as 8 data bits (val[7] first) plus one parity bit. The
// parity bit is a stray BitEn in IDLE for the non-parity instances.

module tb_serial_byte_loader;

   logic CLK = 1'b0;
   logic Clrn, Start, BitEn, SDI;
   logic rdy_m, rdy_l, rdy_p;

   logic [7:0] q_m, q_l, q_p;
   logic v_m, v_l, v_p;
   logic b_m, b_l, b_p;
   logic pe_m, pe_l, pe_p;
   logic ov_m, ov_l, ov_p;

   always #5 CLK = ~CLK;

   serial_byte_loader #(.MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_msb (
      .CLK(CLK), .Clrn(Clrn), .Start(Start), .BitEn(BitEn), .SDI(SDI), .Ready(rdy_m),
      .Q(q_m), .Valid(v_m), .Busy(b_m), .ParErr(pe_m), .Overrun(ov_m));

   serial_byte_loader #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_lsb (
      .CLK(CLK), .Clrn(Clrn), .Start(Start), .BitEn(BitEn), .SDI(SDI), .Ready(rdy_l),
      .Q(q_l), .Valid(v_l), .Busy(b_l), .ParErr(pe_l), .Overrun(ov_l));

   serial_byte_loader #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_par (
      .CLK(CLK), .Clrn(Clrn), .Start(Start), .BitEn(BitEn), .SDI(SDI), .Ready(rdy_p),
      .Q(q_p), .Valid(v_p), .Busy(b_p), .ParErr(pe_p), .Overrun(ov_p));

   int n_chk  = 0;
   int n_pass = 0;

   logic [8:0] exp_m[$];
   logic [8:0] exp_l[$];
   logic [8:0] exp_p[$];

   bit pv[3];
   bit pr[3];
   int ov_cnt[3];
   int ov_snap[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   function automatic string nm(input int i);
      if (i == 0) return "msb";
      if (i == 1) return "lsb";
      return "par";
   endfunction

   task automatic pop_exp(input int i, output logic [8:0] e, output bit ok);
      ok = 1'b0;
      e  = 9'h000;
      case (i)
         0: if (exp_m.size() > 0) begin e = exp_m.pop_front(); ok = 1'b1; end
         1: if (exp_l.size() > 0) begin e = exp_l.pop_front(); ok = 1'b1; end
         default: if (exp_p.size() > 0) begin e = exp_p.pop_front(); ok = 1'b1; end
      endcase
   endtask

   // A load is visible when Valid is 1 now and either it was 0 before or the
   // previous edge sampled Ready=1 (a reload in the accept cycle).
   task automatic mon_one(input int i, input logic v, input logic [7:0] q,
                          input logic pe, input logic ov);
      logic [8:0] e;
      bit ok;
      if (ov) ov_cnt[i]++;
      if (v && (!pv[i] || pr[i])) begin
         pop_exp(i, e, ok);
         chk($sformatf("%s_load_expected", nm(i)), {31'd0, ok}, 32'd1);
         if (ok) begin
            chk($sformatf("%s_q", nm(i)), {24'd0, q}, {24'd0, e[7:0]});
            chk($sformatf("%s_parerr", nm(i)), {31'd0, pe}, {31'd0, e[8]});
         end
      end
      pv[i] = v;
   endtask

   task automatic cyc();
      pr[0] = rdy_m;
      pr[1] = rdy_l;
      pr[2] = rdy_p;
      @(posedge CLK);
      #1;
      if (Clrn) begin
         mon_one(0, v_m, q_m, pe_m, ov_m);
         mon_one(1, v_l, q_l, pe_l, ov_l);
         mon_one(2, v_p, q_p, pe_p, ov_p);
      end
   endtask

   task automatic push_exp(input logic [7:0] val, input logic pbit, input logic [2:0] mask);
      if (mask[0]) exp_m.push_back({1'b0, val});
      if (mask[1]) exp_l.push_back({1'b0, rev8(val)});
      if (mask[2]) exp_p.push_back({^{val, pbit}, val});
   endtask

   task automatic start_frame(input logic be);
      Start = 1'b1;
      BitEn = be;
      SDI   = 1'b1;
      cyc();
      Start = 1'b0;
      BitEn = 1'b0;
   endtask

   // Optional idle gap with junk on SDI, then one strobed bit.
   task automatic send_bit(input logic b, input logic [2:0] rdy);
      if ($urandom_range(0, 1) == 1) begin
         BitEn = 1'b0;
         SDI   = 1'($urandom_range(0, 1));
         cyc();
      end
      BitEn = 1'b1;
      SDI   = b;
      rdy_m = rdy[0];
      rdy_l = rdy[1];
      rdy_p = rdy[2];
      cyc();
      BitEn = 1'b0;
      rdy_m = 1'b0;
      rdy_l = 1'b0;
      rdy_p = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] val, input logic [2:0] rdy_last);
      for (int i = 7; i >= 0; i--)
         send_bit(val[i], (i == 0) ? {1'b0, rdy_last[1:0]} : 3'b000);
      chk("msb_busy_after_8", {31'd0, b_m}, 32'd0);
      chk("par_busy_in_par", {31'd0, b_p}, 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] val, input logic pbit, input logic [2:0] mask,
                             input logic [2:0] rdy_last, input logic be_at_start);
      push_exp(val, pbit, mask);
      start_frame(be_at_start);
      chk("busy_after_start", {29'd0, b_p, b_l, b_m}, 32'd7);
      send_data(val, rdy_last);
      send_bit(pbit, {rdy_last[2], 2'b00});
      chk("par_busy_after_9", {31'd0, b_p}, 32'd0);
   endtask

   task automatic drain();
      rdy_m = 1'b1;
      rdy_l = 1'b1;
      rdy_p = 1'b1;
      cyc();
      rdy_m = 1'b0;
      rdy_l = 1'b0;
      rdy_p = 1'b0;
      chk("valid_after_drain", {29'd0, v_p, v_l, v_m}, 32'd0);
   endtask

   task automatic snap_ov();
      for (int i = 0; i < 3; i++) ov_snap[i] = ov_cnt[i];
   endtask

   task automatic chk_ov(input string tag, input int exp_n);
      for (int i = 0; i < 3; i++)
         chk($sformatf("%s_%s", tag, nm(i)), ov_cnt[i] - ov_snap[i], exp_n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      Clrn  = 1'b0;
      Start = 1'b0;
      BitEn = 1'b0;
      SDI   = 1'b0;
      rdy_m = 1'b0;
      rdy_l = 1'b0;
      rdy_p = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pv[i] = 1'b0;
         pr[i] = 1'b0;
         ov_cnt[i] = 0;
      end

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_q", {8'd0, q_p, q_l, q_m}, 32'd0);
      chk("rst_valid", {29'd0, v_p, v_l, v_m}, 32'd0);
      chk("rst_busy", {29'd0, b_p, b_l, b_m}, 32'd0);
      chk("rst_parerr", {29'd0, pe_p, pe_l, pe_m}, 32'd0);
      chk("rst_overrun", {29'd0, ov_p, ov_l, ov_m}, 32'd0);
      #3 Clrn = 1'b1;
      cyc();

      // basic frame: C0 / 03, parity bit 0
      snap_ov();
      send_frame(8'hC0, 1'b0, 3'b111, 3'b000, 1'b0);
      chk("msb_valid_held", {31'd0, v_m}, 32'd1);
      drain();

      // BitEn in IDLE ignored, BitEn coincident with Start ignored, parity bit 1
      for (int k = 0; k < 3; k++) begin
         BitEn = 1'b1;
         SDI   = 1'b1;
         cyc();
      end
      BitEn = 1'b0;
      chk("idle_biten_busy", {29'd0, b_p, b_l, b_m}, 32'd0);
      chk("idle_biten_valid", {29'd0, v_p, v_l, v_m}, 32'd0);
      send_frame(8'hC0, 1'b1, 3'b111, 3'b000, 1'b1);
      drain();

      // restart after 4 bits, with a coincident bit on the restarting Start
      push_exp(8'h5A, 1'b0, 3'b111);
      start_frame(1'b0);
      for (int k = 0; k < 4; k++) send_bit(1'b1, 3'b000);
      start_frame(1'b1);
      send_data(8'h5A, 3'b000);
      send_bit(1'b0, 3'b000);
      drain();

      // overrun: Ready held low, second byte dropped
      snap_ov();
      send_frame(8'hC0, 1'b0, 3'b111, 3'b000, 1'b0);
      send_frame(8'h3C, 1'b1, 3'b000, 3'b000, 1'b0);
      chk_ov("overrun_pulses", 1);
      chk("overrun_keep_q", {8'd0, q_p, q_l, q_m}, {8'd0, 8'hC0, 8'h03, 8'hC0});
      chk("overrun_valid", {29'd0, v_p, v_l, v_m}, 32'd7);
      drain();

      // completion in the accept cycle: new byte loads, no overrun
      snap_ov();
      send_frame(8'hC0, 1'b0, 3'b111, 3'b000, 1'b0);
      send_frame(8'h3C, 1'b1, 3'b111, 3'b111, 1'b0);
      chk_ov("accept_reload_overrun", 0);
      chk("accept_reload_q", {8'd0, q_p, q_l, q_m}, {8'd0, 8'h3C, 8'h3C, 8'h3C});
      chk("accept_reload_valid", {29'd0, v_p, v_l, v_m}, 32'd7);
      drain();

      // reset mid-frame with a byte pending
      send_frame(8'hC0, 1'b1, 3'b111, 3'b000, 1'b0);
      start_frame(1'b0);
      for (int k = 0; k < 3; k++) send_bit(1'b0, 3'b000);
      #3 Clrn = 1'b0;
      #1;
      chk("midrst_q", {8'd0, q_p, q_l, q_m}, 32'd0);
      chk("midrst_valid", {29'd0, v_p, v_l, v_m}, 32'd0);
      chk("midrst_busy", {29'd0, b_p, b_l, b_m}, 32'd0);
      chk("midrst_parerr", {29'd0, pe_p, pe_l, pe_m}, 32'd0);
      chk("midrst_overrun", {29'd0, ov_p, ov_l, ov_m}, 32'd0);
      #1 Clrn = 1'b1;
      for (int i = 0; i < 3; i++) pv[i] = 1'b0;
      for (int k = 0; k < 6; k++) send_bit(1'b1, 3'b000);
      chk("postrst_valid", {29'd0, v_p, v_l, v_m}, 32'd0);
      chk("postrst_busy", {29'd0, b_p, b_l, b_m}, 32'd0);
      send_frame(8'h3C, 1'b0, 3'b111, 3'b000, 1'b0);
      chk("postrst_frame_valid", {29'd0, v_p, v_l, v_m}, 32'd7);
      drain();

      cyc();
      chk("msb_queue_empty", exp_m.size(), 0);
      chk("lsb_queue_empty", exp_l.size(), 0);
      chk("par_queue_empty", exp_p.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
